hazard_forward_unit: RTL and testbench

Pipeline hazard controller for the 5-stage MIPS core. It keeps its own shadow of the destination and source registers in flight through ID/EX, EX/MEM and MEM/WB. From these it drives the EX stage's `ForwardA`/`ForwardB` mux selects, detects load-use hazards and stalls the front end, squashes wrong-path instructions on a taken branch or jump, and counts stall cycles. It produces the forwarding selects that the EX stage consumes, and it sits beside the pipeline registers between ID and EX.

---
 rtl/hazard_forward_unit_if.sv | 46 ++++
 rtl/hazard_forward_unit.sv | 98 +++++++++
 tb/tb_hazard_forward_unit.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/hazard_forward_unit_if.sv
// rtl/hazard_forward_unit_if.sv - signal bundle between the pipeline and the hazard/forward unit
//
// Purpose: groups the ID/EX/MEM hazard inputs and the forwarding/stall/flush
//          outputs of hazard_forward_unit into one interface.
// Signals:
//   rs_ID, rt_ID       source fields of the instruction in ID
//   rtd_EX             destination of the instruction in EX (after RegDst mux)
//   RegWrite_in_EX     EX instruction writes the register file
//   MemRead_in_EX      EX instruction is a load
//   Branch_MEM         MEM instruction is a beq
//   Zero_MEM           registered Zero flag of the MEM instruction
//   jump_MEM           MEM instruction is a j
//   ForwardA/ForwardB  EX operand selects (0 regfile, 1 WB, 2 MEM)
//   Stall_ID           hold PC and IF/ID, bubble ID/EX
//   Flush              squash IF/ID, ID/EX and EX-to-MEM control
//   stall_count        saturating count of stall cycles
// Modports: master = pipeline side (drives hazard inputs), slave = hazard unit.
interface hazard_forward_unit_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       rs_ID;
    logic [4:0]       rt_ID;
    logic [4:0]       rtd_EX;
    logic             RegWrite_in_EX;
    logic             MemRead_in_EX;
    logic             Branch_MEM;
    logic             Zero_MEM;
    logic             jump_MEM;
    logic [1:0]       ForwardA;
    logic [1:0]       ForwardB;
    logic             Stall_ID;
    logic             Flush;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output rs_ID, rt_ID, rtd_EX, RegWrite_in_EX, MemRead_in_EX,
               Branch_MEM, Zero_MEM, jump_MEM,
        input  ForwardA, ForwardB, Stall_ID, Flush, stall_count
    );

    modport slave (
        input  rs_ID, rt_ID, rtd_EX, RegWrite_in_EX, MemRead_in_EX,
               Branch_MEM, Zero_MEM, jump_MEM,
        output ForwardA, ForwardB, Stall_ID, Flush, stall_count
    );
endinterface

// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - 5-stage MIPS forwarding, load-use stall and flush controller
//
// Purpose: shadows the source/destination registers in flight through
//          ID/EX, EX/MEM and MEM/WB, drives the EX forwarding selects,
//          raises a one-cycle load-use stall, squashes wrong-path work on a
//          taken branch or jump, and counts stall cycles (saturating).
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; clears all shadow state and the counter
//   bus    hazard_forward_unit_if.slave (see interface for signal list)
module hazard_forward_unit #(
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    hazard_forward_unit_if.slave bus
);

    // Shadow pipeline state
    logic [4:0]       r_rs_EX;
    logic [4:0]       r_rt_EX;
    logic [4:0]       r_rtd_MEM;
    logic             r_RegWrite_MEM;
    logic [4:0]       r_rtd_WB;
    logic             r_RegWrite_WB;
    logic [CNT_W-1:0] r_stall_count;

    logic             w_flush;
    logic             w_stall;
    logic             w_load_hit;
    logic [1:0]       w_fwd_a;
    logic [1:0]       w_fwd_b;

    // Select for one EX source: MEM holds the younger writer so it wins over WB.
    // $0 is hard-wired zero and must never be forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       rw_mem,
        input logic [4:0] rtd_mem,
        input logic       rw_wb,
        input logic [4:0] rtd_wb
    );
        if (rw_mem && (rtd_mem != 5'd0) && (rtd_mem == src)) begin
            return 2'd2;
        end else if (rw_wb && (rtd_wb != 5'd0) && (rtd_wb == src)) begin
            return 2'd1;
        end else begin
            return 2'd0;
        end
    endfunction

    always_comb begin
        w_flush    = (bus.Branch_MEM && bus.Zero_MEM) || bus.jump_MEM;
        w_load_hit = bus.MemRead_in_EX && bus.RegWrite_in_EX &&
                     (bus.rtd_EX != 5'd0) &&
                     ((bus.rtd_EX == bus.rs_ID) || (bus.rtd_EX == bus.rt_ID));
        // A flush kills the dependent instruction anyway, so stalling for it
        // would only waste a cycle.
        w_stall    = w_load_hit && !w_flush;
        w_fwd_a    = fwd_sel(r_rs_EX, r_RegWrite_MEM, r_rtd_MEM, r_RegWrite_WB, r_rtd_WB);
        w_fwd_b    = fwd_sel(r_rt_EX, r_RegWrite_MEM, r_rtd_MEM, r_RegWrite_WB, r_rtd_WB);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rs_EX        <= 5'd0;
            r_rt_EX        <= 5'd0;
            r_rtd_MEM      <= 5'd0;
            r_RegWrite_MEM <= 1'b0;
            r_rtd_WB       <= 5'd0;
            r_RegWrite_WB  <= 1'b0;
            r_stall_count  <= '0;
        end else begin
            r_rtd_WB       <= r_rtd_MEM;
            r_RegWrite_WB  <= r_RegWrite_MEM;
            r_rtd_MEM      <= bus.rtd_EX;
            // The squashed EX instruction must never become a MEM writer.
            r_RegWrite_MEM <= bus.RegWrite_in_EX && !w_flush;
            if (w_stall || w_flush) begin
                r_rs_EX <= 5'd0;
                r_rt_EX <= 5'd0;
            end else begin
                r_rs_EX <= bus.rs_ID;
                r_rt_EX <= bus.rt_ID;
            end
            if (w_stall && (r_stall_count != {CNT_W{1'b1}})) begin
                r_stall_count <= r_stall_count + 1'b1;
            end
        end
    end

    assign bus.ForwardA    = w_fwd_a;
    assign bus.ForwardB    = w_fwd_b;
    assign bus.Stall_ID    = w_stall;
    assign bus.Flush       = w_flush;
    assign bus.stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb/tb_hazard_forward_unit.sv - directed self-checking bench for hazard_forward_unit
module tb_hazard_forward_unit;

    localparam int CNT_W = 4;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    hazard_forward_unit_if #(.CNT_W(CNT_W)) bus ();

    hazard_forward_unit #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; return 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic [4:0] rtd, input logic rw, input logic mr);
        bus.rtd_EX         = rtd;
        bus.RegWrite_in_EX = rw;
        bus.MemRead_in_EX  = mr;
    endtask

    task automatic set_id(input logic [4:0] rs, input logic [4:0] rt);
        bus.rs_ID = rs;
        bus.rt_ID = rt;
    endtask

    task automatic set_mem(input logic br, input logic z, input logic j);
        bus.Branch_MEM = br;
        bus.Zero_MEM   = z;
        bus.jump_MEM   = j;
    endtask

    task automatic nop_all();
        set_ex(5'd0, 1'b0, 1'b0);
        set_id(5'd0, 5'd0);
        set_mem(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        nop_all();
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("reset_fwdA", 16'(bus.ForwardA), 16'd0);
        chk("reset_fwdB", 16'(bus.ForwardB), 16'd0);
        chk("reset_cnt", 16'(bus.stall_count), 16'd0);
        chk("reset_stall", 16'(bus.Stall_ID), 16'd0);
        chk("reset_flush", 16'(bus.Flush), 16'd0);

        // EX->EX: add $3 in EX, sub rs=$3 rt=$4 in ID
        set_ex(5'd3, 1'b1, 1'b0);
        set_id(5'd3, 5'd4);
        tick();
        set_ex(5'd10, 1'b1, 1'b0);
        set_id(5'd0, 5'd0);
        #1;
        chk("exex_fwdA", 16'(bus.ForwardA), 16'd2);
        chk("exex_fwdB", 16'(bus.ForwardB), 16'd0);
        nop_all();
        tick(); tick(); tick();

        // Two writers of $5, consumer rt=$5: younger (MEM) wins
        set_ex(5'd5, 1'b1, 1'b0);
        tick();
        set_ex(5'd5, 1'b1, 1'b0);
        set_id(5'd7, 5'd5);
        tick();
        set_ex(5'd12, 1'b0, 1'b0);
        set_id(5'd0, 5'd0);
        #1;
        chk("prio_fwdB", 16'(bus.ForwardB), 16'd2);
        chk("prio_fwdA", 16'(bus.ForwardA), 16'd0);
        nop_all();
        tick(); tick(); tick();

        // Only the older writer ($6) left, now in WB
        set_ex(5'd6, 1'b1, 1'b0);
        tick();
        set_ex(5'd0, 1'b0, 1'b0);
        set_id(5'd6, 5'd6);
        tick();
        set_id(5'd0, 5'd0);
        #1;
        chk("wb_fwdA", 16'(bus.ForwardA), 16'd1);
        chk("wb_fwdB", 16'(bus.ForwardB), 16'd1);
        nop_all();
        tick(); tick(); tick();

        // Writer to $0 is never forwarded
        set_ex(5'd0, 1'b1, 1'b0);
        set_id(5'd0, 5'd0);
        tick();
        set_ex(5'd0, 1'b0, 1'b0);
        #1;
        chk("r0_fwdA", 16'(bus.ForwardA), 16'd0);
        chk("r0_fwdB", 16'(bus.ForwardB), 16'd0);
        // Load into $0 with matching ID fields is not a hazard
        set_ex(5'd0, 1'b1, 1'b1);
        #1;
        chk("r0_nostall", 16'(bus.Stall_ID), 16'd0);
        nop_all();
        tick(); tick(); tick();

        // Load-use: lw $8 in EX, consumer rs=$2 rt=$8 in ID
        set_ex(5'd8, 1'b1, 1'b1);
        set_id(5'd2, 5'd8);
        #1;
        chk("lu_stall", 16'(bus.Stall_ID), 16'd1);
        chk("lu_flush", 16'(bus.Flush), 16'd0);
        tick();
        set_ex(5'd0, 1'b0, 1'b0);
        #1;
        chk("lu_cnt1", 16'(bus.stall_count), 16'd1);
        chk("lu_stall_off", 16'(bus.Stall_ID), 16'd0);
        chk("lu_bubble_rs", 16'(dut.r_rs_EX), 16'd0);
        chk("lu_bubble_rt", 16'(dut.r_rt_EX), 16'd0);
        chk("lu_bubble_fwdB", 16'(bus.ForwardB), 16'd0);
        tick();
        set_id(5'd0, 5'd0);
        #1;
        chk("lu_wb_fwdB", 16'(bus.ForwardB), 16'd1);
        chk("lu_wb_fwdA", 16'(bus.ForwardA), 16'd0);
        chk("lu_cnt_hold", 16'(bus.stall_count), 16'd1);
        nop_all();
        tick(); tick(); tick();

        // Taken branch with simultaneous load-use on $9
        set_mem(1'b1, 1'b1, 1'b0);
        set_ex(5'd9, 1'b1, 1'b1);
        set_id(5'd9, 5'd0);
        #1;
        chk("br_flush", 16'(bus.Flush), 16'd1);
        chk("br_stall", 16'(bus.Stall_ID), 16'd0);
        tick();
        set_mem(1'b0, 1'b0, 1'b0);
        set_ex(5'd0, 1'b0, 1'b0);
        set_id(5'd9, 5'd9);
        #1;
        chk("br_cnt", 16'(bus.stall_count), 16'd1);
        chk("br_rw_mem", 16'(dut.r_RegWrite_MEM), 16'd0);
        chk("br_bubble_rs", 16'(dut.r_rs_EX), 16'd0);
        tick();
        set_id(5'd0, 5'd0);
        #1;
        // Squashed $9 writer reached WB without RegWrite
        chk("br_no_fwdA", 16'(bus.ForwardA), 16'd0);
        chk("br_no_fwdB", 16'(bus.ForwardB), 16'd0);

        // Jump alone flushes; branch not taken does not
        set_mem(1'b0, 1'b0, 1'b1);
        #1;
        chk("jump_flush", 16'(bus.Flush), 16'd1);
        set_mem(1'b1, 1'b0, 1'b0);
        #1;
        chk("bnt_flush", 16'(bus.Flush), 16'd0);
        nop_all();
        tick(); tick(); tick();

        // Saturation: hold stall condition for 20 cycles starting from 1
        set_ex(5'd8, 1'b1, 1'b1);
        set_id(5'd0, 5'd8);
        for (int i = 0; i < 5; i++) tick();
        chk("sat_cnt6", 16'(bus.stall_count), 16'd6);
        for (int i = 0; i < 15; i++) tick();
        chk("sat_cnt15", 16'(bus.stall_count), 16'd15);
        chk("sat_stall", 16'(bus.Stall_ID), 16'd1);
        tick();
        chk("sat_hold", 16'(bus.stall_count), 16'd15);

        // Build forwarding state, then reset discards it
        set_ex(5'd8, 1'b1, 1'b0);
        set_id(5'd8, 5'd8);
        tick();
        chk("pre_rst_fwdA", 16'(bus.ForwardA), 16'd2);
        chk("pre_rst_fwdB", 16'(bus.ForwardB), 16'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        nop_all();
        #1;
        chk("rst_cnt", 16'(bus.stall_count), 16'd0);
        chk("rst_fwdA", 16'(bus.ForwardA), 16'd0);
        chk("rst_fwdB", 16'(bus.ForwardB), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
